// File: rtl/node_pu_dispatcher_pkg.sv
// Shared dispatcher/preallocator definitions: PU count, degree-class encodings,
// per-class PU demand and FSM state type.
package node_pu_dispatcher_pkg;

  localparam int unsigned NUM_PU_DEFAULT = 16;

  localparam logic [1:0] CLASS_HIGH = 2'b10;
  localparam logic [1:0] CLASS_MED  = 2'b01;

  localparam int unsigned PU_CNT_HIGH   = 12;
  localparam int unsigned PU_CNT_MED    = 4;
  localparam int unsigned PU_CNT_NORMAL = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } disp_state_t;

  // PU demand for a degree class, never more than the PUs that exist.
  function automatic int unsigned pu_count_for_class(input logic [1:0] cls,
                                                     input int unsigned num_pu);
    int unsigned n;
    case (cls)
      CLASS_HIGH: n = PU_CNT_HIGH;
      CLASS_MED:  n = PU_CNT_MED;
      default:    n = PU_CNT_NORMAL;
    endcase
    return (n > num_pu) ? num_pu : n;
  endfunction

endpackage

// File: rtl/node_pu_dispatcher_select.sv
// Combinational lowest-N picker: marks the `count` lowest-indexed set bits of
// free_mask and reports how many bits of free_mask are set.
module pu_lowest_n_select
  import node_pu_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PU = NUM_PU_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(NUM_PU) + 1
) (
  input  logic [NUM_PU-1:0] free_mask,
  input  logic [CNT_W-1:0]  count,
  output logic [NUM_PU-1:0] sel_mask,
  output logic [CNT_W-1:0]  free_count
);

  logic [CNT_W-1:0] taken;

  always_comb begin
    sel_mask   = '0;
    free_count = '0;
    taken      = '0;
    for (int unsigned i = 0; i < NUM_PU; i++) begin
      if (free_mask[i]) begin
        free_count = free_count + CNT_W'(1);
        if (taken < count) begin
          sel_mask[i] = 1'b1;
          taken       = taken + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/node_pu_dispatcher.sv
// Frontier-node dispatcher: accepts one node request at a time and grants it
// the lowest-indexed free PUs once enough are available, in arrival order.
module node_pu_dispatcher
  import node_pu_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_PU = NUM_PU_DEFAULT,
  parameter int unsigned NODE_W = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      node_valid,
  output logic                      node_ready,
  input  logic [NODE_W-1:0]         node_id,
  input  logic [1:0]                node_class,
  input  logic [NUM_PU-1:0]         pu_done,
  output logic                      grant_valid,
  output logic [NUM_PU-1:0]         grant_mask,
  output logic [NODE_W-1:0]         grant_node_id,
  output logic [NUM_PU-1:0]         busy_mask,
  output logic [$clog2(NUM_PU):0]   free_count,
  output logic [15:0]               stall_cycles
);

  localparam int unsigned CNT_W = $clog2(NUM_PU) + 1;

  disp_state_t       state_q, state_d;
  logic [NODE_W-1:0] req_id_q;
  logic [CNT_W-1:0]  req_cnt_q;
  logic [CNT_W-1:0]  req_cnt_new;
  logic [NUM_PU-1:0] free_mask;
  logic [NUM_PU-1:0] sel_mask;
  logic [CNT_W-1:0]  free_pop;
  logic              accept;
  logic              do_grant;
  logic              do_stall;

  assign req_cnt_new = CNT_W'(pu_count_for_class(node_class, NUM_PU));
  assign free_mask   = ~busy_mask;
  assign free_count  = free_pop;
  assign node_ready  = (state_q == ST_IDLE);

  // Selection sees only the registered occupancy; same-cycle releases count next cycle.
  pu_lowest_n_select #(
    .NUM_PU (NUM_PU),
    .CNT_W  (CNT_W)
  ) u_select (
    .free_mask  (free_mask),
    .count      (req_cnt_q),
    .sel_mask   (sel_mask),
    .free_count (free_pop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    do_grant = 1'b0;
    do_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (node_valid) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (free_pop >= req_cnt_q) begin
          do_grant = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          do_stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_id_q      <= '0;
      req_cnt_q     <= '0;
      grant_valid   <= 1'b0;
      grant_mask    <= '0;
      grant_node_id <= '0;
      busy_mask     <= '0;
      stall_cycles  <= '0;
    end else begin
      grant_valid <= do_grant;
      if (accept) begin
        req_id_q  <= node_id;
        req_cnt_q <= req_cnt_new;
      end
      if (do_grant) begin
        grant_mask    <= sel_mask;
        grant_node_id <= req_id_q;
      end
      // Granted bits are free by construction, so they never collide with a release.
      busy_mask <= (busy_mask & ~pu_done) | (do_grant ? sel_mask : '0);
      if (do_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_node_pu_dispatcher.sv
// Self-checking bench for node_pu_dispatcher (NUM_PU=16): directed scenarios
// followed by randomized traffic, compared against a transaction-level model.
module tb_node_pu_dispatcher;

  localparam int NPU = 16;
  localparam int NW  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          node_valid = 1'b0;
  logic          node_ready;
  logic [NW-1:0] node_id = '0;
  logic [1:0]    node_class = '0;
  logic [NPU-1:0] pu_done = '0;
  logic          grant_valid;
  logic [NPU-1:0] grant_mask;
  logic [NW-1:0] grant_node_id;
  logic [NPU-1:0] busy_mask;
  logic [4:0]    free_count;
  logic [15:0]   stall_cycles;

  int passes = 0;
  int checks = 0;

  // Reference model state
  logic [NPU-1:0] m_busy, m_gmask;
  logic [NW-1:0]  m_id, m_gid;
  bit             m_gv, m_pend;
  int             m_cnt, m_stall;

  always #5 clk = ~clk;

  node_pu_dispatcher #(
    .NUM_PU (NPU),
    .NODE_W (NW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .node_valid    (node_valid),
    .node_ready    (node_ready),
    .node_id       (node_id),
    .node_class    (node_class),
    .pu_done       (pu_done),
    .grant_valid   (grant_valid),
    .grant_mask    (grant_mask),
    .grant_node_id (grant_node_id),
    .busy_mask     (busy_mask),
    .free_count    (free_count),
    .stall_cycles  (stall_cycles)
  );

  function automatic int popc(input logic [NPU-1:0] v);
    int n = 0;
    for (int i = 0; i < NPU; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [NPU-1:0] lowest(input logic [NPU-1:0] fm, input int n);
    logic [NPU-1:0] r = '0;
    int k = 0;
    for (int i = 0; i < NPU; i++)
      if (fm[i] && k < n) begin
        r[i] = 1'b1;
        k++;
      end
    return r;
  endfunction

  function automatic int need(input logic [1:0] c);
    int n;
    n = (c == 2'b10) ? 12 : (c == 2'b01) ? 4 : 1;
    return (n > NPU) ? NPU : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = '0; m_gmask = '0; m_id = '0; m_gid = '0;
    m_gv = 0; m_pend = 0; m_cnt = 0; m_stall = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":grant_valid"},   32'(grant_valid),   32'(m_gv));
    chk({tag, ":grant_mask"},    32'(grant_mask),    32'(m_gmask));
    chk({tag, ":grant_node_id"}, 32'(grant_node_id), 32'(m_gid));
    chk({tag, ":busy_mask"},     32'(busy_mask),     32'(m_busy));
    chk({tag, ":free_count"},    32'(free_count),    32'(NPU - popc(m_busy)));
    chk({tag, ":stall_cycles"},  32'(stall_cycles),  32'(m_stall));
    chk({tag, ":node_ready"},    32'(node_ready),    32'(!m_pend));
  endtask

  // One clock: drive inputs, advance the model by one edge, sample #1 after it.
  task automatic cycle(input string tag, input bit v, input logic [1:0] c,
                       input logic [NW-1:0] id, input logic [NPU-1:0] done);
    int free;
    logic [NPU-1:0] gnew;
    bit g;
    node_valid = v; node_class = c; node_id = id; pu_done = done;
    free = NPU - popc(m_busy);
    gnew = '0;
    g = 0;
    if (!m_pend) begin
      if (v) begin
        m_pend = 1; m_cnt = need(c); m_id = id;
      end
    end else if (free >= m_cnt) begin
      g = 1; gnew = lowest(~m_busy, m_cnt);
      m_gmask = gnew; m_gid = m_id; m_pend = 0;
    end else if (m_stall < 65535) begin
      m_stall++;
    end
    m_gv = g;
    m_busy = (m_busy & ~done) | gnew;
    @(posedge clk);
    #1;
    node_valid = 0; pu_done = '0;
    check_all(tag);
  endtask

  initial begin
    int s0, waits;
    model_reset();

    // Reset values
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single normal-class request: grant two samples after accept
    cycle("r033_acc", 1, 2'b00, 20'd5, '0);
    chk("r033_no_grant_yet", 32'(grant_valid), 32'd0);
    cycle("r033_gnt", 0, 2'b00, '0, '0);
    chk("r033_gv", 32'(grant_valid), 32'd1);
    chk("r033_mask", 32'(grant_mask), 32'h0001);
    chk("r033_id", 32'(grant_node_id), 32'd5);
    chk("r033_free", 32'(free_count), 32'd15);
    cycle("r033_rel", 0, 2'b00, '0, 16'h0001);

    // High then medium from empty
    cycle("r034_acc_hi", 1, 2'b10, 20'd7, '0);
    cycle("r034_gnt_hi", 0, 2'b00, '0, '0);
    chk("r034_mask_hi", 32'(grant_mask), 32'h0FFF);
    cycle("r034_acc_med", 1, 2'b01, 20'd8, '0);
    cycle("r034_gnt_med", 0, 2'b00, '0, '0);
    chk("r034_mask_med", 32'(grant_mask), 32'hF000);
    chk("r034_free", 32'(free_count), 32'd0);

    // All busy: stall, then release four PUs
    cycle("r035_acc", 1, 2'b01, 20'd9, '0);
    s0 = int'(stall_cycles);
    for (int k = 0; k < 3; k++) cycle("r035_wait", 0, 2'b00, '0, '0);
    chk("r035_stall", 32'(stall_cycles), 32'(s0 + 3));
    cycle("r035_rel", 0, 2'b00, '0, 16'h000F);
    chk("r035_no_grant_on_release", 32'(grant_valid), 32'd0);
    cycle("r035_gnt", 0, 2'b00, '0, '0);
    chk("r035_gv", 32'(grant_valid), 32'd1);
    chk("r035_mask", 32'(grant_mask), 32'h000F);
    cycle("r035_relall", 0, 2'b00, '0, 16'hFFFF);

    // busy 0FFF, high-class request accepted alongside pu_done[0]
    cycle("r036_fill_acc", 1, 2'b10, 20'd10, '0);
    cycle("r036_fill_gnt", 0, 2'b00, '0, '0);
    cycle("r036_acc", 1, 2'b10, 20'd11, 16'h0001);
    s0 = int'(stall_cycles);
    for (int k = 1; k <= 7; k++) begin
      logic [NPU-1:0] d;
      d = '0;
      d[k] = 1'b1;
      cycle("r036_wait", 0, 2'b00, '0, d);
    end
    waits = 7;
    for (int k = 0; k < 20 && !grant_valid; k++) begin
      cycle("r036_poll", 0, 2'b00, '0, '0);
      if (!grant_valid) waits++;
    end
    chk("r036_gv", 32'(grant_valid), 32'd1);
    chk("r036_mask", 32'(grant_mask), 32'hF0FF);
    chk("r036_stall_len", 32'(int'(stall_cycles) - s0), 32'(waits));
    chk("r036_stall_exact", 32'(waits), 32'd7);
    cycle("r036_relall", 0, 2'b00, '0, 16'hFFFF);

    // Release of an idle PU is ignored
    cycle("r037_acc", 1, 2'b00, 20'd12, '0);
    cycle("r037_gnt", 0, 2'b00, '0, '0);
    cycle("r037_idle_done", 0, 2'b00, '0, 16'h8000);
    chk("r037_busy", 32'(busy_mask), 32'h0001);
    cycle("r037_rel", 0, 2'b00, '0, 16'h0001);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle("rand", bit'($urandom_range(0, 1)), 2'($urandom), NW'($urandom),
            NPU'($urandom & $urandom & $urandom));
    end
    for (int k = 0; k < 20; k++) cycle("drain", 0, 2'b00, '0, 16'hFFFF);

    // Reset while waiting drops the request
    cycle("r038_acc_hi", 1, 2'b10, 20'd20, '0);
    cycle("r038_gnt_hi", 0, 2'b00, '0, '0);
    cycle("r038_acc_med", 1, 2'b01, 20'd21, '0);
    cycle("r038_gnt_med", 0, 2'b00, '0, '0);
    cycle("r038_acc", 1, 2'b00, 20'd22, '0);
    cycle("r038_wait", 0, 2'b00, '0, '0);
    chk("r038_in_wait", 32'(node_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("r038_async");
    chk("r038_free", 32'(free_count), 32'd16);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle("r038_after", 0, 2'b00, '0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
